// File: rtl/scan_obf_shifter.sv
// scan_obf_shifter: captures a state word, shifts it out as se/so pairs, masking so with an LFSR when the key is wrong
module scan_obf_shifter #(
    parameter int          CHAIN_LEN   = 16,
    parameter logic [7:0]  CORRECT_KEY = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] capture_data,
    input  logic [7:0]           key,
    input  logic                 si,
    output logic                 se,
    output logic                 so,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] chain_out
);
    localparam int CW = $clog2(CHAIN_LEN) + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, DONE} state_t;

    state_t               state, state_nxt;
    logic [CHAIN_LEN-1:0] sreg;
    logic [7:0]           lfsr;
    logic [CW-1:0]        cnt;
    logic                 key_ok;
    logic [7:0]           seed;

    assign seed = key ^ CORRECT_KEY;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state and outputs, decoded purely from registered state and data
    always_comb begin
        state_nxt = state;
        se        = 1'b0;
        so        = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        chain_out = sreg;
        case (state)
            IDLE:    state_nxt = start ? CAPTURE : IDLE;
            CAPTURE: begin
                busy      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT:   begin
                se        = 1'b1;
                busy      = 1'b1;
                so        = sreg[CHAIN_LEN-1] ^ (lfsr[0] & ~key_ok);
                state_nxt = (cnt == CW'(CHAIN_LEN - 1)) ? DONE : SHIFT;
            end
            DONE:    begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // chain, mask generator, shift counter and key verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg   <= '0;
            lfsr   <= 8'h01;
            cnt    <= '0;
            key_ok <= 1'b0;
        end else if (state == CAPTURE) begin
            sreg   <= capture_data;
            key_ok <= (key == CORRECT_KEY);
            cnt    <= '0;
            lfsr   <= (seed == 8'h00) ? 8'h01 : seed;
        end else if (state == SHIFT) begin
            sreg <= {sreg[CHAIN_LEN-2:0], si};
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            cnt  <= cnt + 1'b1;
        end
    end
endmodule
